// File: rtl/pitch_frame_loader_pkg.sv
`default_nettype none
// =============================================================================
// pitch_frame_loader_pkg : loader state encoding and frame-geometry helpers
// Revision: 1.0
// =============================================================================
package pitch_frame_loader_pkg;

   typedef enum logic [2:0] {
      ST_FILL     = 3'd0,
      ST_START    = 3'd1,
      ST_BUSY     = 3'd2,
      ST_REPORT   = 3'd3,
      ST_HOP_WAIT = 3'd4
   } loader_state_t;

   // Frame length F: analysis window plus the lag span the analyzer looks ahead by.
   function automatic int frame_len(input int window_size_bits, input int max_tau);
      return (1 << window_size_bits) + max_tau;
   endfunction

   function automatic int counter_width(input int frame, input int timeout);
      return $clog2(((frame > timeout) ? frame : timeout) + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pitch_frame_loader_frame_shift_reg.sv
`default_nettype none
// =============================================================================
// frame_shift_reg : DEPTH-slot parallel-out shift register, newest in top slot
// Revision: 1.0
// =============================================================================
module frame_shift_reg
   import pitch_frame_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        shift_en,
   input  logic [DATA_WIDTH-1:0]       din,
   output logic [DEPTH*DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] slot_q [DEPTH];
   logic [DATA_WIDTH-1:0] slot_d [DEPTH];

   always_comb begin
      for (int k = 0; k < DEPTH - 1; k++) begin
         slot_d[k] = shift_en ? slot_q[k+1] : slot_q[k];
      end
      slot_d[DEPTH-1] = shift_en ? din : slot_q[DEPTH-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         slot_q <= slot_d;
      end
   end

   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_slot
         assign dout[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/pitch_frame_loader.sv
`default_nettype none
// =============================================================================
// pitch_frame_loader : gathers hopping sample frames and sequences the analyzer
// Revision: 1.0
// =============================================================================
module pitch_frame_loader
   import pitch_frame_loader_pkg::*;
#(
   parameter int DATA_WIDTH       = 8,
   parameter int WINDOW_SIZE_BITS = 8,
   parameter int MAX_TAU          = 40,
   parameter int HOP              = 64,
   parameter int TIMEOUT          = 65535
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] sample,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic [frame_len(WINDOW_SIZE_BITS, MAX_TAU)*DATA_WIDTH-1:0] data,
   output logic                  analysis_reset,
   input  logic                  analysis_ready,
   input  logic [7:0]            analysis_tau,
   output logic [7:0]            pitch_tau,
   output logic                  pitch_valid,
   output logic                  timeout_err
);

   localparam int F     = frame_len(WINDOW_SIZE_BITS, MAX_TAU);
   localparam int CNT_W = counter_width(F, TIMEOUT);

   localparam logic [CNT_W-1:0] FILL_LAST    = CNT_W'(F - 1);
   localparam logic [CNT_W-1:0] HOP_LAST     = CNT_W'(HOP - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   loader_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic [7:0]       pitch_tau_q, pitch_tau_d;
   logic             timeout_err_q, timeout_err_d;
   logic             accept;

   // ready_q is the registered image of "next state accepts", so it stays low
   // through reset and rises on the first clock after release.
   assign accept = sample_valid & ready_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pitch_tau_d   = pitch_tau_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         ST_FILL: begin
            if (accept) begin
               if (cnt_q == FILL_LAST) begin
                  state_d = ST_START;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         ST_START: begin
            state_d = ST_BUSY;
            cnt_d   = '0;
         end
         ST_BUSY: begin
            // First BUSY cycle may still see the previous frame's ready level.
            if ((cnt_q != '0) && analysis_ready) begin
               pitch_tau_d   = analysis_tau;
               timeout_err_d = 1'b0;
               state_d       = ST_REPORT;
            end else if (cnt_q == TIMEOUT_LAST) begin
               pitch_tau_d   = '0;
               timeout_err_d = 1'b1;
               state_d       = ST_REPORT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_REPORT: begin
            state_d = ST_HOP_WAIT;
            cnt_d   = '0;
         end
         ST_HOP_WAIT: begin
            if (accept) begin
               if (cnt_q == HOP_LAST) begin
                  state_d = ST_START;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = ST_FILL;
            cnt_d   = '0;
         end
      endcase
      ready_d = (state_d == ST_FILL) || (state_d == ST_HOP_WAIT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_FILL;
         cnt_q         <= '0;
         ready_q       <= 1'b0;
         pitch_tau_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ready_q       <= ready_d;
         pitch_tau_q   <= pitch_tau_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   frame_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (F)
   ) u_frame (
      .clk      (clk),
      .reset    (reset),
      .shift_en (accept),
      .din      (sample),
      .dout     (data)
   );

   assign sample_ready   = ready_q;
   assign analysis_reset = (state_q != ST_BUSY);
   assign pitch_valid    = (state_q == ST_REPORT);
   assign pitch_tau      = pitch_tau_q;
   assign timeout_err    = timeout_err_q;

endmodule
`default_nettype wire
